// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select codes, flag bit positions and the
// packed width of one queued ALU result entry.
package alu_pkg;

   localparam logic [3:0] ADD = 4'd0;
   localparam logic [3:0] SUB = 4'd1;
   localparam logic [3:0] MUL = 4'd2;
   localparam logic [3:0] ROL = 4'd3;
   localparam logic [3:0] ROR = 4'd4;
   localparam logic [3:0] NEG = 4'd5;
   localparam logic [3:0] ABS = 4'd6;
   localparam logic [3:0] MAX = 4'd7;
   localparam logic [3:0] MIN = 4'd8;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_V = 2;
   localparam int FLG_S = 3;

   localparam int ENTRY_W = 40;

   // Flags travel as {sign, ovf, zero, carry}.
   function automatic logic [3:0] pack_flags(input logic carry, input logic zero,
                                             input logic ovf, input logic sign);
      logic [3:0] f;
      f        = 4'b0000;
      f[FLG_C] = carry;
      f[FLG_Z] = zero;
      f[FLG_V] = ovf;
      f[FLG_S] = sign;
      return f;
   endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Handshake bus between the ALU, the result queue and the writeback consumer.
interface alu_result_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [3:0]  in_sel;
   logic        in_carry;
   logic        in_zero;
   logic        in_ovf;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_sel;
   logic [3:0]  out_flags;

   modport slave (
      input  in_valid, in_result, in_sel, in_carry, in_zero, in_ovf, in_sign, out_ready,
      output in_ready, out_valid, out_result, out_sel, out_flags
   );

   modport master (
      output in_valid, in_result, in_sel, in_carry, in_zero, in_ovf, in_sign, out_ready,
      input  in_ready, out_valid, out_result, out_sel, out_flags
   );
endinterface

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage with separately tracked occupancy. Ready/valid
// are registered and never depend combinationally on the opposite side.
module sync_fifo_core #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_req,
   input  logic                     pop_req,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     push_ok,
   output logic                     not_full,
   output logic                     not_empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_s;
   logic             not_full_r;
   logic             not_empty_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push_req && not_full_r;
   assign pop_s  = pop_req && not_empty_r;

   // Next occupancy from the qualified push/pop pair.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CW'(1);
         2'b01:   count_s = count_r - CW'(1);
         default: count_s = count_r;
      endcase
   end

   // Pointers, occupancy and the registered ready/valid status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CW{1'b0}};
         not_full_r  <= 1'b1;
         not_empty_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         count_r     <= count_s;
         not_full_r  <= (count_s != FULL_CNT);
         not_empty_r <= (count_s != {CW{1'b0}});
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= wr_data;
   end

   assign rd_data   = mem_r[rd_ptr_r];
   assign push_ok   = push_s;
   assign not_full  = not_full_r;
   assign not_empty = not_empty_r;
   assign count     = count_r;
endmodule

// File: rtl/alu_result_queue.sv
// Result/flag capture queue behind the ALU, with sticky carry/overflow
// status and a saturating overflow-event counter.
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_result_queue_if.slave      bus,
   input  logic                   clr_sticky,
   output logic [$clog2(DEPTH):0] count,
   output logic                   sticky_carry,
   output logic                   sticky_ovf,
   output logic [CNT_W-1:0]       ovf_events
);
   localparam logic [CNT_W-1:0] EV_MAX = {CNT_W{1'b1}};

   logic [ENTRY_W-1:0] wr_entry_s;
   logic [ENTRY_W-1:0] rd_entry_s;
   logic               push_s;
   logic               sticky_carry_r;
   logic               sticky_carry_s;
   logic               sticky_ovf_r;
   logic               sticky_ovf_s;
   logic [CNT_W-1:0]   ovf_events_r;
   logic [CNT_W-1:0]   ovf_events_s;

   assign wr_entry_s = {bus.in_sel,
                        pack_flags(bus.in_carry, bus.in_zero, bus.in_ovf, bus.in_sign),
                        bus.in_result};

   sync_fifo_core #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_req  (bus.in_valid),
      .pop_req   (bus.out_ready),
      .wr_data   (wr_entry_s),
      .rd_data   (rd_entry_s),
      .push_ok   (push_s),
      .not_full  (bus.in_ready),
      .not_empty (bus.out_valid),
      .count     (count)
   );

   assign bus.out_sel    = rd_entry_s[39:36];
   assign bus.out_flags  = rd_entry_s[35:32];
   assign bus.out_result = rd_entry_s[31:0];

   // Sticky/counter next state: a qualifying push beats a coincident clear.
   always_comb begin
      sticky_carry_s = sticky_carry_r;
      sticky_ovf_s   = sticky_ovf_r;
      ovf_events_s   = ovf_events_r;
      if (push_s && bus.in_carry) sticky_carry_s = 1'b1;
      else if (clr_sticky)        sticky_carry_s = 1'b0;
      else                        sticky_carry_s = sticky_carry_r;
      if (push_s && bus.in_ovf) begin
         sticky_ovf_s = 1'b1;
         if (clr_sticky)                  ovf_events_s = CNT_W'(1);
         else if (ovf_events_r == EV_MAX) ovf_events_s = EV_MAX;
         else                             ovf_events_s = ovf_events_r + CNT_W'(1);
      end else if (clr_sticky) begin
         sticky_ovf_s = 1'b0;
         ovf_events_s = {CNT_W{1'b0}};
      end else begin
         sticky_ovf_s = sticky_ovf_r;
         ovf_events_s = ovf_events_r;
      end
   end

   // Exception status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_carry_r <= 1'b0;
         sticky_ovf_r   <= 1'b0;
         ovf_events_r   <= {CNT_W{1'b0}};
      end else begin
         sticky_carry_r <= sticky_carry_s;
         sticky_ovf_r   <= sticky_ovf_s;
         ovf_events_r   <= ovf_events_s;
      end
   end

   assign sticky_carry = sticky_carry_r;
   assign sticky_ovf   = sticky_ovf_r;
   assign ovf_events   = ovf_events_r;
endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench: directed table, corner sequences and random traffic
// against a queue-based reference model.
module tb_alu_result_queue;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int EVMAX = 15;

   logic             clk;
   logic             rst;
   logic             clr_sticky;
   logic [2:0]       count;
   logic             sticky_carry;
   logic             sticky_ovf;
   logic [CNT_W-1:0] ovf_events;

   alu_result_queue_if bus ();

   alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .clr_sticky   (clr_sticky),
      .count        (count),
      .sticky_carry (sticky_carry),
      .sticky_ovf   (sticky_ovf),
      .ovf_events   (ovf_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of {sel, flags, result} plus status.
   logic [39:0] mq[$];
   logic        m_sc;
   logic        m_sv;
   int          m_ev;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [31:0] res;
      logic [3:0]  sel;
      logic [3:0]  flg;
      logic [2:0]  ecnt;
      logic        eov;
      logic        eir;
      logic [31:0] eres;
      logic [3:0]  eflg;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic model_check();
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
      chk("sticky_carry", 64'(sticky_carry), 64'(m_sc));
      chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sv));
      chk("ovf_events", 64'(ovf_events), 64'(m_ev));
      if (mq.size() != 0) begin
         chk("out_result", 64'(bus.out_result), 64'(mq[0][31:0]));
         chk("out_flags", 64'(bus.out_flags), 64'(mq[0][35:32]));
         chk("out_sel", 64'(bus.out_sel), 64'(mq[0][39:36]));
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_sc = 1'b0;
      m_sv = 1'b0;
      m_ev = 0;
   endtask

   // One clock of stimulus; flg is {sign, ovf, zero, carry}.
   task automatic cyc(input logic iv, input logic ordy, input logic [31:0] res,
                      input logic [3:0] sel, input logic [3:0] flg, input logic clr);
      logic push;
      logic pop;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      bus.in_result = res;
      bus.in_sel    = sel;
      bus.in_carry  = flg[0];
      bus.in_zero   = flg[1];
      bus.in_ovf    = flg[2];
      bus.in_sign   = flg[3];
      clr_sticky    = clr;
      push = iv && (mq.size() < DEPTH);
      pop  = ordy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({sel, flg, res});
      if (push && flg[0]) m_sc = 1'b1;
      else if (clr)       m_sc = 1'b0;
      if (push && flg[2]) begin
         m_sv = 1'b1;
         m_ev = clr ? 1 : ((m_ev == EVMAX) ? EVMAX : m_ev + 1);
      end else if (clr) begin
         m_sv = 1'b0;
         m_ev = 0;
      end
      model_check();
   endtask

   initial begin
      rst = 1'b1;
      clr_sticky = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_result = 32'd0;
      bus.in_sel = 4'd0;
      bus.in_carry = 1'b0;
      bus.in_zero = 1'b0;
      bus.in_ovf = 1'b0;
      bus.in_sign = 1'b0;
      model_reset();

      tbl[0]  = '{1'b1, 1'b0, 32'd5, ADD, 4'b0001, 3'd1, 1'b1, 1'b1, 32'd5, 4'b0001};
      tbl[1]  = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd0, 4'b0000};
      tbl[2]  = '{1'b1, 1'b0, 32'd1, SUB, 4'b0000, 3'd1, 1'b1, 1'b1, 32'd1, 4'b0000};
      tbl[3]  = '{1'b1, 1'b0, 32'd2, MUL, 4'b0000, 3'd2, 1'b1, 1'b1, 32'd1, 4'b0000};
      tbl[4]  = '{1'b1, 1'b0, 32'd3, ROL, 4'b0000, 3'd3, 1'b1, 1'b1, 32'd1, 4'b0000};
      tbl[5]  = '{1'b1, 1'b0, 32'd4, ROR, 4'b0000, 3'd4, 1'b1, 1'b0, 32'd1, 4'b0000};
      tbl[6]  = '{1'b1, 1'b0, 32'd9, NEG, 4'b0000, 3'd4, 1'b1, 1'b0, 32'd1, 4'b0000};
      tbl[7]  = '{1'b1, 1'b1, 32'd5, ABS, 4'b0000, 3'd3, 1'b1, 1'b1, 32'd2, 4'b0000};
      tbl[8]  = '{1'b1, 1'b0, 32'd5, ABS, 4'b0000, 3'd4, 1'b1, 1'b0, 32'd2, 4'b0000};
      tbl[9]  = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd3, 1'b1, 1'b1, 32'd3, 4'b0000};
      tbl[10] = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd2, 1'b1, 1'b1, 32'd4, 4'b0000};
      tbl[11] = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd1, 1'b1, 1'b1, 32'd5, 4'b0000};
      tbl[12] = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd0, 4'b0000};
      tbl[13] = '{1'b1, 1'b1, 32'd7, MAX, 4'b0010, 3'd1, 1'b1, 1'b1, 32'd7, 4'b0010};
      tbl[14] = '{1'b1, 1'b1, 32'd8, MIN, 4'b0000, 3'd1, 1'b1, 1'b1, 32'd8, 4'b0000};
      tbl[15] = '{1'b0, 1'b1, 32'd0, ADD, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd0, 4'b0000};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_sticky", 64'({sticky_carry, sticky_ovf}), 64'd0);
      chk("rst_ovf_events", 64'(ovf_events), 64'd0);
      rst = 1'b0;

      // Directed fill/drain, full-with-pop, wrap and empty push+pop.
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].iv, tbl[i].ordy, tbl[i].res, tbl[i].sel, tbl[i].flg, 1'b0);
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].eov));
         chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].eir));
         if (tbl[i].eov) begin
            chk($sformatf("tbl%0d_result", i), 64'(bus.out_result), 64'(tbl[i].eres));
            chk($sformatf("tbl%0d_flags", i), 64'(bus.out_flags), 64'(tbl[i].eflg));
         end
      end

      // Overflow status, coincident clear, then saturation.
      cyc(1'b0, 1'b0, 32'd0, ADD, 4'b0000, 1'b1);
      chk("clr_sticky_carry", 64'(sticky_carry), 64'd0);
      cyc(1'b1, 1'b0, 32'h8000_0000, ADD, 4'b1100, 1'b0);
      chk("ovf_sticky", 64'(sticky_ovf), 64'd1);
      chk("ovf_events1", 64'(ovf_events), 64'd1);
      chk("ovf_flags", 64'(bus.out_flags), 64'b1100);
      cyc(1'b0, 1'b1, 32'd0, ADD, 4'b0000, 1'b0);
      cyc(1'b1, 1'b0, 32'h8000_0001, ADD, 4'b1010, 1'b0);
      chk("ovf_flags_1010", 64'(bus.out_flags), 64'b1010);
      cyc(1'b1, 1'b1, 32'h8000_0000, ADD, 4'b1100, 1'b1);
      chk("clr_vs_push_sticky", 64'(sticky_ovf), 64'd1);
      chk("clr_vs_push_events", 64'(ovf_events), 64'd1);
      for (int i = 0; i < 20; i++)
         cyc(1'b1, 1'b1, 32'(i), SUB, 4'b0100, 1'b0);
      chk("ovf_saturate", 64'(ovf_events), 64'd15);
      cyc(1'b0, 1'b0, 32'd0, ADD, 4'b0000, 1'b1);
      chk("clr_events", 64'(ovf_events), 64'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom(),
             4'($urandom_range(0, 8)), 4'($urandom()), 1'($urandom_range(0, 15) == 0));

      // Asynchronous reset with three entries queued.
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b0, 1'b1, 32'd0, ADD, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 32'(100 + i), ADD, 4'b0101, 1'b0);
      chk("pre_rst_count", 64'(count), 64'd3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_sticky", 64'({sticky_carry, sticky_ovf}), 64'd0);
      chk("async_rst_events", 64'(ovf_events), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(1'b1, 1'b0, 32'hDEAD_BEEF, MAX, 4'b0010, 1'b0);
      chk("post_rst_result", 64'(bus.out_result), 64'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
